// File: rtl/cmac_tx_arb_pkg.sv
// Shared types and constants for the CMAC TX two-requester packet arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cmac_tx_arb_pkg;

    localparam int DEF_DATA_W = 512;
    localparam int DEF_KEEP_W = DEF_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT0,
        ST_GRANT1,
        ST_DRAIN0,
        ST_DRAIN1
    } arb_state_e;

    // Width needed to hold a beat index up to and including max_beats.
    function automatic int beat_cnt_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice between the arbiter and the CMAC TX port.
// Latency: 1 cycle from accepted input to out_vld_o when empty.
// Backpressure: in_rdy_o depends only on registered occupancy; output held stable while stalled.
// Ports: clk_i/rst_ni, in_vld_i/in_rdy_o/in_dat_i (upstream), out_vld_o/out_rdy_i/out_dat_o (downstream).
module axis_skid_buf #(
    parameter int W = 578
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         push;
    logic         pop;

    // Ready while a slot is free; never looks at out_rdy_i.
    assign in_rdy_o  = (cnt_q != 2'd2);
    assign out_vld_o = (cnt_q != 2'd0);
    assign out_dat_o = mem_q[rd_ptr_q];

    assign push = in_vld_i & in_rdy_o;
    assign pop  = out_vld_o & out_rdy_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cmac_tx_axis_arb.sv
// Packet-level round-robin arbiter sharing the CMAC TX AXI-Stream port between two sources.
// Latency: one arbitration bubble from IDLE, then 1 cycle source-to-m_axis through the skid stage.
// Backpressure: owner's tready follows the skid stage's registered ready; loser sees tready=0.
// Ports: aclk/aresetn, enable, s0_axis_* (packet generator), s1_axis_* (ERNIC), m_axis_* (CMAC),
//        grant (one-hot owner), pkt_cnt0/pkt_cnt1 (wrapping), trunc_cnt (saturating).
module cmac_tx_axis_arb
    import cmac_tx_arb_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int KEEP_W        = DATA_W / 8,
    parameter int CNT_W         = 16,
    parameter int MAX_PKT_BEATS = 256
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic [KEEP_W-1:0] s0_axis_tkeep,
    input  logic              s0_axis_tlast,
    input  logic              s0_axis_tuser,
    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic [KEEP_W-1:0] s1_axis_tkeep,
    input  logic              s1_axis_tlast,
    input  logic              s1_axis_tuser,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic [CNT_W-1:0]  trunc_cnt
);

    localparam int              BC_W     = beat_cnt_w(MAX_PKT_BEATS);
    localparam int              PAY_W    = DATA_W + KEEP_W + 2;
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(MAX_PKT_BEATS - 1);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0]  pkt_cnt1_q, pkt_cnt1_d;
    logic [CNT_W-1:0]  trunc_cnt_q, trunc_cnt_d;

    logic              own1, in_grant;
    logic              src_vld, src_rdy, src_last, src_user;
    logic [DATA_W-1:0] src_data;
    logic [KEEP_W-1:0] src_keep;
    logic              acc, push, force_trunc, out_last, out_user;
    logic              cand0, cand1, pick1, take_arb;
    arb_state_e        arb_nxt;
    logic              skid_rdy;

    assign own1     = (state_q == ST_GRANT1) || (state_q == ST_DRAIN1);
    assign in_grant = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);

    assign src_vld  = own1 ? s1_axis_tvalid : s0_axis_tvalid;
    assign src_last = own1 ? s1_axis_tlast  : s0_axis_tlast;
    assign src_user = own1 ? s1_axis_tuser  : s0_axis_tuser;
    assign src_data = own1 ? s1_axis_tdata  : s0_axis_tdata;
    assign src_keep = own1 ? s1_axis_tkeep  : s0_axis_tkeep;

    // Drain states swallow the remainder of a truncated packet at full rate.
    assign s0_axis_tready = (state_q == ST_GRANT0) ? skid_rdy : (state_q == ST_DRAIN0);
    assign s1_axis_tready = (state_q == ST_GRANT1) ? skid_rdy : (state_q == ST_DRAIN1);
    assign src_rdy        = own1 ? s1_axis_tready : s0_axis_tready;

    assign acc         = src_vld & src_rdy;
    assign push        = in_grant & acc;
    assign force_trunc = in_grant & (beat_cnt_q == LAST_IDX) & ~src_last;
    assign out_last    = src_last | force_trunc;
    assign out_user    = src_user | force_trunc;

    // Round-robin pick: on a tie the requester not granted last wins.
    assign cand0   = enable & s0_axis_tvalid;
    assign cand1   = enable & s1_axis_tvalid;
    assign pick1   = cand1 & (~cand0 | ~last_grant_q);
    assign arb_nxt = !(cand0 | cand1) ? ST_IDLE : (pick1 ? ST_GRANT1 : ST_GRANT0);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        take_arb     = 1'b0;
        unique case (state_q)
            ST_IDLE: take_arb = 1'b1;
            ST_GRANT0, ST_GRANT1: begin
                if (acc) begin
                    if (src_last) begin
                        take_arb   = 1'b1;
                        beat_cnt_d = '0;
                    end else if (force_trunc) begin
                        state_d    = own1 ? ST_DRAIN1 : ST_DRAIN0;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN0, ST_DRAIN1: begin
                if (acc && src_last) begin
                    take_arb = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take_arb) begin
            state_d = arb_nxt;
            if (cand0 | cand1) begin
                last_grant_d = pick1;
            end
        end
    end

    assign pkt_cnt0_d  = pkt_cnt0_q + CNT_W'(push & out_last & ~own1);
    assign pkt_cnt1_d  = pkt_cnt1_q + CNT_W'(push & out_last & own1);
    assign trunc_cnt_d = trunc_cnt_q + CNT_W'(push & force_trunc & ~(&trunc_cnt_q));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
            trunc_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
            trunc_cnt_q  <= trunc_cnt_d;
        end
    end

    assign grant     = {own1, (state_q == ST_GRANT0) || (state_q == ST_DRAIN0)};
    assign pkt_cnt0  = pkt_cnt0_q;
    assign pkt_cnt1  = pkt_cnt1_q;
    assign trunc_cnt = trunc_cnt_q;

    axis_skid_buf #(
        .W(PAY_W)
    ) u_skid (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .in_vld_i (push),
        .in_rdy_o (skid_rdy),
        .in_dat_i ({src_data, src_keep, out_last, out_user}),
        .out_vld_o(m_axis_tvalid),
        .out_rdy_i(m_axis_tready),
        .out_dat_o({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser})
    );

endmodule

// File: tb/tb_cmac_tx_axis_arb.sv
// Self-checking bench for cmac_tx_axis_arb: random payloads against a packet-order scoreboard.
// Latency: n/a.
// Backpressure: sink tready is either held high or randomised per cycle.
module tb_cmac_tx_axis_arb;

    localparam int DW   = 512;
    localparam int KW   = 64;
    localparam int CW   = 16;
    localparam int MAXB = 256;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;
    localparam int BW = $bits(beat_t);

    logic          aclk;
    logic          aresetn;
    logic          enable;
    logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast, s0_axis_tuser;
    logic [DW-1:0] s0_axis_tdata;
    logic [KW-1:0] s0_axis_tkeep;
    logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast, s1_axis_tuser;
    logic [DW-1:0] s1_axis_tdata;
    logic [KW-1:0] s1_axis_tkeep;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [1:0]    grant;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1, trunc_cnt;

    cmac_tx_axis_arb #(
        .DATA_W(DW), .KEEP_W(KW), .CNT_W(CW), .MAX_PKT_BEATS(MAXB)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_cnt(trunc_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    beat_t src0_q[$];
    beat_t src1_q[$];
    beat_t exp_q[$];
    beat_t pkt_tmp[$];

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         out_cnt = 0;
    int         first_out_cyc = -1, last_out_cyc = -1;
    int         first_sv_cyc = -1, first_mv_cyc = -1;
    logic [1:0] gnt_or = 2'b00, first_gnt = 2'b00;
    logic       rnd_mode = 1'b0;
    logic       held = 1'b0;
    beat_t      held_b;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds one packet into pkt_tmp and queues it on the chosen source.
    function automatic void gen_pkt(input int src, input int len, input logic [KW-1:0] last_keep);
        beat_t b;
        pkt_tmp.delete();
        for (int i = 0; i < len; i++) begin
            for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
            b.keep = (i == len - 1) ? last_keep : '1;
            b.last = (i == len - 1);
            b.user = ($urandom_range(0, 15) == 0);
            pkt_tmp.push_back(b);
            if (src == 0) src0_q.push_back(b);
            else          src1_q.push_back(b);
        end
    endfunction

    // Reference: a packet leaves intact, or cut to MAXB beats with the cut beat marked last+error.
    function automatic void expect_pkt();
        beat_t e;
        int    n;
        n = (pkt_tmp.size() > MAXB) ? MAXB : pkt_tmp.size();
        for (int i = 0; i < n; i++) begin
            e = pkt_tmp[i];
            if (i == MAXB - 1 && pkt_tmp.size() > MAXB) begin
                e.last = 1'b1;
                e.user = 1'b1;
            end
            exp_q.push_back(e);
        end
    endfunction

    task automatic do_reset();
        aresetn = 1'b0;
        enable  = 1'b1;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        repeat (2) @(negedge aclk);
        aresetn       = 1'b1;
        out_cnt       = 0;
        first_out_cyc = -1;
        last_out_cyc  = -1;
        first_sv_cyc  = -1;
        first_mv_cyc  = -1;
        gnt_or        = 2'b00;
        first_gnt     = 2'b00;
        held          = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge aclk);
        check(tag, BW'(exp_q.size()), BW'(0));
    endtask

    // Source drivers and sink monitor: sample at negedge, drive 1 time unit after posedge.
    initial begin
        logic  a0, a1;
        beat_t ob, eb;
        s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0;
        s0_axis_tlast  = 1'b0; s0_axis_tuser = 1'b0;
        s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0;
        s1_axis_tlast  = 1'b0; s1_axis_tuser = 1'b0;
        m_axis_tready  = 1'b1;
        forever begin
            @(negedge aclk);
            a0 = s0_axis_tvalid & s0_axis_tready;
            a1 = s1_axis_tvalid & s1_axis_tready;
            ob = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (held && aresetn) begin
                check("stall_vld", BW'(m_axis_tvalid), BW'(1'b1));
                check("stall_hold", ob, held_b);
            end
            held   = aresetn & m_axis_tvalid & ~m_axis_tready;
            held_b = ob;
            if (aresetn && m_axis_tvalid && m_axis_tready) begin
                check("out_avail", BW'(exp_q.size() > 0), BW'(1'b1));
                if (exp_q.size() > 0) begin
                    eb = exp_q.pop_front();
                    check("out_beat", ob, eb);
                end
                if (out_cnt == 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                out_cnt++;
            end
            if (first_sv_cyc < 0 && s0_axis_tvalid) first_sv_cyc = cyc;
            if (first_mv_cyc < 0 && m_axis_tvalid)  first_mv_cyc = cyc;
            gnt_or = gnt_or | grant;
            if (first_gnt == 2'b00) first_gnt = grant;
            @(posedge aclk);
            cyc++;
            #1;
            if (a0 && src0_q.size() > 0) void'(src0_q.pop_front());
            if (a1 && src1_q.size() > 0) void'(src1_q.pop_front());
            s0_axis_tvalid = (src0_q.size() > 0);
            if (src0_q.size() > 0)
                {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast, s0_axis_tuser} = src0_q[0];
            s1_axis_tvalid = (src1_q.size() > 0);
            if (src1_q.size() > 0)
                {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast, s1_axis_tuser} = src1_q[0];
            m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        enable  = 1'b1;
        #23;
        check("rst_m_vld",  BW'(m_axis_tvalid), BW'(1'b0));
        check("rst_m_beat", BW'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), BW'(0));
        check("rst_grant",  BW'(grant), BW'(2'b00));
        check("rst_tready", BW'({s0_axis_tready, s1_axis_tready}), BW'(2'b00));
        check("rst_cnts",   BW'({pkt_cnt0, pkt_cnt1, trunc_cnt}), BW'(0));

        // Port 0 alone: three 9-beat packets, contiguous output.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            gen_pkt(0, 9, 64'h3FF);
            expect_pkt();
        end
        wait_drain("p0_drain", 200);
        check("p0_latency", BW'(first_mv_cyc - first_sv_cyc), BW'(2));
        check("p0_out_cnt", BW'(out_cnt), BW'(27));
        check("p0_contig",  BW'(last_out_cyc - first_out_cyc), BW'(26));
        check("p0_pkt_cnt", BW'({pkt_cnt0, pkt_cnt1}), BW'({16'd3, 16'd0}));
        check("p0_grant",   BW'(gnt_or), BW'(2'b01));

        // Both ports continuously valid: strict alternation starting with port 0, no gaps.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            gen_pkt(0, 4, '1); expect_pkt();
            gen_pkt(1, 4, '1); expect_pkt();
        end
        wait_drain("rr_drain", 200);
        check("rr_out_cnt", BW'(out_cnt), BW'(32));
        check("rr_contig",  BW'(last_out_cyc - first_out_cyc), BW'(31));
        check("rr_pkt_cnt", BW'({pkt_cnt0, pkt_cnt1}), BW'({16'd4, 16'd4}));

        // Random lengths with random sink backpressure.
        do_reset();
        rnd_mode = 1'b1;
        for (int p = 0; p < 10; p++) begin
            gen_pkt(0, $urandom_range(1, 12), KW'($urandom_range(1, 255))); expect_pkt();
            gen_pkt(1, $urandom_range(1, 12), KW'($urandom_range(1, 255))); expect_pkt();
        end
        wait_drain("rnd_drain", 3000);
        check("rnd_pkt_cnt", BW'({pkt_cnt0, pkt_cnt1}), BW'({16'd10, 16'd10}));
        check("rnd_trunc",   BW'(trunc_cnt), BW'(0));
        rnd_mode = 1'b0;

        // Overlong packet on port 1, then an intact port-0 packet.
        do_reset();
        gen_pkt(1, 300, '1); expect_pkt();
        for (int i = 0; i < 20 && grant != 2'b10; i++) @(negedge aclk);
        check("tr_grant1", BW'(grant), BW'(2'b10));
        gen_pkt(0, 5, 64'hF); expect_pkt();
        wait_drain("tr_drain", 1000);
        check("tr_out_cnt",  BW'(out_cnt), BW'(261));
        check("tr_consumed", BW'(src1_q.size()), BW'(0));
        check("tr_cnts",     BW'({trunc_cnt, pkt_cnt1, pkt_cnt0}), BW'({16'd1, 16'd1, 16'd1}));

        // enable gating: no grant while low, in-flight packet completes after it drops.
        do_reset();
        enable = 1'b0;
        gen_pkt(0, 6, '1); expect_pkt();
        gen_pkt(1, 6, '1); expect_pkt();
        repeat (10) @(negedge aclk);
        check("en0_grant",  BW'(grant), BW'(2'b00));
        check("en0_tready", BW'({s0_axis_tready, s1_axis_tready}), BW'(2'b00));
        check("en0_out",    BW'(out_cnt), BW'(0));
        enable = 1'b1;
        for (int i = 0; i < 10 && grant == 2'b00; i++) @(negedge aclk);
        check("en1_grant", BW'(grant), BW'(2'b01));
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        enable = 1'b0;
        repeat (20) @(negedge aclk);
        check("en_mid_out",   BW'(out_cnt), BW'(6));
        check("en_mid_grant", BW'(grant), BW'(2'b00));
        check("en_mid_cnts",  BW'({pkt_cnt0, pkt_cnt1}), BW'({16'd1, 16'd0}));
        enable = 1'b1;
        wait_drain("en_drain", 100);
        check("en_cnt1", BW'(pkt_cnt1), BW'(1));

        // Reset in the middle of the second packet, then port 0 wins the first tie.
        do_reset();
        gen_pkt(0, 3, '1); expect_pkt();
        gen_pkt(0, 8, '1); expect_pkt();
        for (int i = 0; i < 50 && out_cnt < 7; i++) @(negedge aclk);
        check("mr_progress", BW'(out_cnt), BW'(7));
        #1 aresetn = 1'b0;
        #1;
        check("mr_m_vld", BW'(m_axis_tvalid), BW'(1'b0));
        check("mr_cnts",  BW'({pkt_cnt0, pkt_cnt1, trunc_cnt}), BW'(0));
        check("mr_grant", BW'(grant), BW'(2'b00));
        do_reset();
        gen_pkt(0, 2, '1); expect_pkt();
        gen_pkt(1, 2, '1); expect_pkt();
        wait_drain("mr_drain", 100);
        check("mr_first_gnt", BW'(first_gnt), BW'(2'b01));
        check("mr_pkt_cnts",  BW'({pkt_cnt0, pkt_cnt1}), BW'({16'd1, 16'd1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
